// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game: direction encoding, block size
// and button indexing used by the direction controller.
package snake_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  localparam int unsigned BLOCK_PX = 20;

  // Button slots, ordered so that a lower index wins on simultaneous presses.
  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned BTN_U   = 0;
  localparam int unsigned BTN_L   = 1;
  localparam int unsigned BTN_D   = 2;
  localparam int unsigned BTN_R   = 3;

  // Opposite directions differ only in bit 0 (LEFT/RIGHT, UP/DOWN).
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button;
// emits a one-cycle registered strobe when the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronised input disagrees with the
  // accepted level; agreeing again (any bounce back) clears it.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced button presses update a pending
// direction that is committed once every FRAMES_PER_STEP frame ticks.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FRAMES_PER_STEP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_u,
  input  logic       btn_l,
  input  logic       btn_d,
  input  logic       btn_r,
  input  logic       frame_tick,
  output logic [1:0] dir,
  output logic       step,
  output logic       turned
);

  localparam int unsigned FcW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FcW-1:0] FcMax = FcW'(FRAMES_PER_STEP - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw = {btn_r, btn_d, btn_l, btn_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk_i (clk),
      .rst_ni(rst_n),
      .btn_i (btn_raw[i]),
      .rise_o(btn_rise[i])
    );
  end

  dir_t           dir_q, dir_d;
  dir_t           pending_q, pending_d;
  dir_t           sel_dir;
  logic           sel_valid;
  logic           accept;
  logic           tick_q;
  logic           tick_edge;
  logic           wrap;
  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic           step_q, step_d;
  logic           turned_q, turned_d;

  always_comb begin
    sel_valid = 1'b1;
    sel_dir   = RIGHT;
    if (btn_rise[BTN_U]) begin
      sel_dir = UP;
    end else if (btn_rise[BTN_L]) begin
      sel_dir = LEFT;
    end else if (btn_rise[BTN_D]) begin
      sel_dir = DOWN;
    end else if (btn_rise[BTN_R]) begin
      sel_dir = RIGHT;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Reversal is judged against the committed direction, so two quick presses
  // inside one step interval can never chain into a U-turn.
  assign accept    = sel_valid && (sel_dir != reverse_dir(dir_q));
  assign pending_d = accept ? sel_dir : pending_q;

  assign tick_edge = frame_tick && !tick_q;
  assign wrap      = tick_edge && (frame_cnt_q == FcMax);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (tick_edge) begin
      frame_cnt_d = wrap ? '0 : frame_cnt_q + 1'b1;
    end
  end

  assign step_d   = wrap;
  assign dir_d    = wrap ? pending_d : dir_q;
  assign turned_d = wrap && (pending_d != dir_q);

  // tick_q resets high so a frame_tick already high at reset release is not
  // mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= RIGHT;
      pending_q   <= RIGHT;
      tick_q      <= 1'b1;
      frame_cnt_q <= '0;
      step_q      <= 1'b0;
      turned_q    <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      tick_q      <= frame_tick;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      turned_q    <= turned_d;
    end
  end

  assign dir    = dir_q;
  assign step   = step_q;
  assign turned = turned_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=4.
module tb_snake_dir_ctrl;

  localparam int BU = 0;
  localparam int BL = 1;
  localparam int BD = 2;
  localparam int BR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_u = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_d = 1'b0;
  logic       btn_r = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] dir;
  logic       step;
  logic       turned;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;
  int unsigned rise_u_cnt = 0;
  int unsigned rise_u_cyc = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_u     (btn_u),
    .btn_l     (btn_l),
    .btn_d     (btn_d),
    .btn_r     (btn_r),
    .frame_tick(frame_tick),
    .dir       (dir),
    .step      (step),
    .turned    (turned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (dut.btn_rise[0]) begin
      rise_u_cnt <= rise_u_cnt + 1;
      rise_u_cyc <= cyc_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      BU:      btn_u = v;
      BL:      btn_l = v;
      BD:      btn_d = v;
      default: btn_r = v;
    endcase
  endtask

  // Hold long enough to debounce the press, then release and let it settle.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic tick_pulse(output logic s, output logic t, output logic [1:0] d);
    frame_tick = 1'b1;
    @(negedge clk);
    s = step;
    t = turned;
    d = dir;
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_step(output logic early, output logic s, output logic t,
                         output logic [1:0] d);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_pulse(s, t, d);
      early |= s;
    end
    tick_pulse(s, t, d);
  endtask

  initial begin
    logic        s, t, e, prev;
    logic [1:0]  d;
    int unsigned base, t0, nsteps, nhigh, nturn;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dir", dir, 1);
    check("rst_step", step, 0);
    check("rst_turned", turned, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First step follows the 4th frame_tick edge
    for (int i = 0; i < 3; i++) begin
      tick_pulse(s, t, d);
      check("init_no_step", s, 0);
    end
    tick_pulse(s, t, d);
    check("init_step", s, 1);
    check("init_turned", t, 0);
    check("init_dir", d, 1);
    check("init_step_width", step, 0);

    // Bouncing UP button: one event, 6 cycles after the final edge
    base = rise_u_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_u = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_u = 1'b1;
    t0 = cyc_cnt;
    repeat (10) @(negedge clk);
    check("bounce_events", rise_u_cnt - base, 1);
    check("bounce_latency", rise_u_cyc - t0, 6);
    btn_u = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_release_events", rise_u_cnt - base, 1);
    do_step(e, s, t, d);
    check("bounce_early", e, 0);
    check("bounce_step", s, 1);
    check("bounce_dir", d, 2);
    check("bounce_turned", t, 1);

    // Reversal rejected; turning via an intermediate step is fine
    press(BR);
    do_step(e, s, t, d);
    check("rev_setup_dir", d, 1);
    check("rev_setup_turned", t, 1);
    press(BL);
    do_step(e, s, t, d);
    check("rev_reject_step", s, 1);
    check("rev_reject_dir", d, 1);
    check("rev_reject_turned", t, 0);
    press(BU);
    do_step(e, s, t, d);
    check("rev_up_dir", d, 2);
    press(BL);
    do_step(e, s, t, d);
    check("rev_left_dir", d, 0);
    check("rev_left_turned", t, 1);

    // Anti-U-turn: committed UP, RIGHT then DOWN in one interval
    press(BU);
    do_step(e, s, t, d);
    check("uturn_setup_dir", d, 2);
    press(BR);
    press(BD);
    do_step(e, s, t, d);
    check("uturn_dir", d, 1);
    check("uturn_turned", t, 1);

    // Committed RIGHT: DOWN accepted, later LEFT rejected, DOWN survives
    press(BD);
    press(BL);
    do_step(e, s, t, d);
    check("last_wins_dir", d, 3);
    press(BL);
    do_step(e, s, t, d);
    check("to_left_dir", d, 0);

    // UP and RIGHT debounce in the very cycle that carries the wrapping edge
    for (int i = 0; i < 3; i++) begin
      tick_pulse(s, t, d);
      check("coinc_no_step", s, 0);
    end
    btn_u = 1'b1;
    btn_r = 1'b1;
    repeat (6) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    check("coinc_step", step, 1);
    check("coinc_dir", dir, 2);
    check("coinc_turned", turned, 1);
    frame_tick = 1'b0;
    btn_u = 1'b0;
    btn_r = 1'b0;
    repeat (8) @(negedge clk);

    // Cadence: 12 wide frame_tick pulses -> 3 single-cycle steps
    nsteps = 0;
    nhigh = 0;
    nturn = 0;
    prev = 1'b0;
    for (int p = 0; p < 12; p++) begin
      frame_tick = 1'b1;
      for (int c = 0; c < 5; c++) begin
        if (c == 3) frame_tick = 1'b0;
        @(negedge clk);
        if (step) nhigh++;
        if (step && !prev) nsteps++;
        if (turned) nturn++;
        prev = step;
      end
    end
    check("cadence_pulses", nsteps, 3);
    check("cadence_high_cycles", nhigh, 3);
    check("cadence_turned", nturn, 0);
    check("cadence_dir", dir, 2);

    // Reset mid-run with a tick edge in progress and UP held across release
    tick_pulse(s, t, d);
    tick_pulse(s, t, d);
    base = rise_u_cnt;
    btn_u = 1'b1;
    frame_tick = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_dir", dir, 1);
    check("midrst_step", step, 0);
    check("midrst_turned", turned, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    do_step(e, s, t, d);
    check("midrst_early", e, 0);
    check("midrst_step_after", s, 1);
    check("midrst_held_dir", d, 2);
    check("midrst_held_turned", t, 1);
    check("midrst_events", rise_u_cnt - base, 1);
    btn_u = 1'b0;
    repeat (8) @(negedge clk);

    // Pending is reset too: a quiet step after reset keeps RIGHT
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_step(e, s, t, d);
    check("rst_pending_step", s, 1);
    check("rst_pending_dir", d, 1);
    check("rst_pending_turned", t, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
